// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and streams them gaplessly.
// Optional even-parity bit per word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_last
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam int unsigned CW = $clog2(NBITS);
    localparam logic [CW-1:0] LastCnt = CW'(NBITS - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state;
    logic [NBITS-1:0] sreg;
    logic [NBITS-1:0] load_word;
    logic [NBITS-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             accept;
    logic             head;

    // Parity sits at the tail of the shift order so it leaves after all data bits.
    always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
        if (MSB_FIRST) begin
            load_word = {in_data, ^in_data};
        end else begin
            load_word = {^in_data, in_data};
        end
`else
        load_word = in_data;
`endif
    end

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg[NBITS-2:0], 1'b0};
            head    = sreg[NBITS-1];
        end else begin
            shifted = {1'b0, sreg[NBITS-1:1]};
            head    = sreg[0];
        end
    end

    assign last_bit   = (state == StShift) && (bit_cnt == LastCnt);
    assign in_ready   = (state == StIdle) || last_bit;
    assign accept     = in_valid && in_ready;
    assign x_valid    = (state == StShift);
    assign x          = x_valid & head;
    assign frame_last = last_bit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= StIdle;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        sreg    <= load_word;
                        bit_cnt <= '0;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (accept) begin
                            sreg <= load_word;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        sreg    <= shifted;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (MSB-first and LSB-first instances).
// Expected streams are 9-bit hand-computed {data bits in emission order, parity}; parity is used only when enabled.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data, in_data1;
    logic       in_valid, in_valid1;
    logic       in_ready, in_ready1;
    logic       x, x1, x_valid, x_valid1, frame_last, frame_last1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .frame_last (frame_last)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .x          (x1),
        .x_valid    (x_valid1),
        .frame_last (frame_last1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_xvalid"}, x_valid, 1'b0);
        chk({tag, "_x"}, x, 1'b0);
        chk({tag, "_last"}, frame_last, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    // Call in the cycle after the first word's accept edge. Non-last cycles drive junk on
    // in_data to show it is ignored while in_ready is low.
    task automatic stream(input string tag, input logic [17:0] exp, input int nwords,
                          input logic [7:0] d2);
        for (int j = 0; j < nwords * NB; j++) begin
            int w = j / NB;
            int b = j % NB;
            chk($sformatf("%s_xvalid%0d", tag, j), x_valid, 1'b1);
            chk($sformatf("%s_x%0d", tag, j), x, exp[17 - 9 * w - b]);
            chk($sformatf("%s_last%0d", tag, j), frame_last, b == NB - 1);
            chk($sformatf("%s_ready%0d", tag, j), in_ready, b == NB - 1);
            if (j == NB - 1) begin
                in_data  = d2;
                in_valid = (nwords == 2);
            end else begin
                in_data = 8'(j * 37 + 5);
            end
            if (j == 2 * NB - 1) in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_valid1 = 1'b0; in_data1 = 8'h00;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_lsb_xvalid", x_valid1, 1'b0);
        chk("reset_lsb_ready", in_ready1, 1'b1);
        rst = 1'b1;
        tick();

        // Single word A5, MSB first
        in_data = 8'hA5; in_valid = 1'b1;
        chk("a5_ready_pre", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        stream("a5", {9'b101001010, 9'b0}, 1, 8'h00);
        chk_idle("a5_after");

        // Back-to-back AA then 0F with in_valid held
        in_data = 8'hAA; in_valid = 1'b1;
        tick();
        stream("b2b", {9'b101010100, 9'b000011110}, 2, 8'h0F);
        chk_idle("b2b_after");

        // Backpressure: junk data while busy, real second word only on the last-bit cycle
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        stream("bp", {9'b001111000, 9'b100000010}, 2, 8'h81);
        chk_idle("bp_after");

        // Parity words 07 (parity 1) and 03 (parity 0)
        in_data = 8'h07; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        stream("w07", {9'b000001111, 9'b0}, 1, 8'h00);
        in_data = 8'h03; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        stream("w03", {9'b000000110, 9'b0}, 1, 8'h00);
        chk_idle("w03_after");

        // LSB first: 01 -> 1,0,0,0,0,0,0,0 (parity 1)
        begin
            logic [8:0] exp1 = 9'b100000001;
            in_data1 = 8'h01; in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            for (int i = 0; i < NB; i++) begin
                chk($sformatf("lsb_xvalid%0d", i), x_valid1, 1'b1);
                chk($sformatf("lsb_x%0d", i), x1, exp1[8 - i]);
                chk($sformatf("lsb_last%0d", i), frame_last1, i == NB - 1);
                tick();
            end
            chk("lsb_after_xvalid", x_valid1, 1'b0);
            chk("lsb_after_ready", in_ready1, 1'b1);
        end

        // Reset mid-word at bit 3 of FF
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_x%0d", i), x, 1'b1);
            tick();
        end
        rst = 1'b0;
        tick();
        chk_idle("mid_rst");
        rst = 1'b1;
        for (int i = 0; i < NB; i++) begin
            tick();
            chk($sformatf("mid_quiet%0d", i), x_valid, 1'b0);
        end

        // Reset coincident with accept: word dropped
        rst = 1'b0; in_data = 8'hFF; in_valid = 1'b1;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        chk_idle("rst_vs_acc");
        tick();
        chk("rst_vs_acc_quiet", x_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end that feeds the serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`.
- `x_valid` qualifies each bit, and `frame_last` marks the final bit of each word.
- Back-to-back words stream with no idle cycle, so the downstream detector sees a continuous bit stream.

Parameters:
- WIDTH, 8, data word width in bits (minimum 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- x  output  1  serial data bit to the detector.
- x_valid  output  1  x carries a valid bit this cycle.
- frame_last  output  1  current x is the last bit of the word (parity bit when PARITY_EN is defined).

Behaviour:
- Reset: one clock and reset; rst is synchronous and active-low.
  - rst=0 at a clk edge sets state=IDLE, shift register=0, bit_cnt=0.
  - Outputs after reset: x=0, x_valid=0, frame_last=0, in_ready=1.
- Accept: a word is accepted at an edge where in_valid=1 and in_ready=1.
- States:
  - IDLE: in_ready=1, x_valid=0, x=0. On accept, load the shift register and set bit_cnt=0, then go to SHIFT.
  - SHIFT: x_valid=1; x = current head bit of the shift register (MSB when MSB_FIRST=1, else LSB).
    - Each edge shifts by one bit and increments bit_cnt.
  - Last bit: bit_cnt==NBITS-1, where NBITS = WIDTH (WIDTH+1 with PARITY_EN).
    - frame_last=1 and in_ready=1 in this cycle, combinationally from state and bit_cnt.
    - On accept: reload, bit_cnt=0, stay in SHIFT. The first bit of the new word appears the very next cycle (gapless).
    - No accept: go to IDLE.
- in_ready is 0 in SHIFT except on the last-bit cycle. in_data and in_valid are ignored when in_ready=0.
- Latency: word accepted at edge k, so bit 0 of the stream is on x during the cycle after edge k. The last bit is on x during cycle k+NBITS.
- x, x_valid and frame_last are driven from registered state only. x never depends combinationally on in_data.
- bit_cnt width is clog2(NBITS). It never exceeds NBITS-1 and wraps to 0 only via reload or return to IDLE.
- Simultaneous rst=0 and accept: reset wins and the word is dropped.
- Reset mid-word: the partial word is discarded; the next cycle is IDLE with x_valid=0.
- in_valid held high continuously: produces an unbroken stream with x_valid=1 every cycle.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined: each word is followed by one even-parity bit (XOR of all WIDTH data bits), so NBITS=WIDTH+1. frame_last and in_ready assert on the parity-bit cycle.
- Undefined: no parity bit, NBITS=WIDTH, and no parity logic is synthesized.

Test Plan:
- Reset then single word: rst=0 for 2 cycles, release, accept 8'hA5 with MSB_FIRST=1.
  - x_valid high 8 cycles; x = 1,0,1,0,0,1,0,1.
  - frame_last only on the 8th bit; then IDLE with in_ready=1.
- Back-to-back: in_valid held with 8'hAA then 8'h0F.
  - 16 consecutive x_valid cycles, x = 10101010 00001111.
  - in_ready high only on bit cycles 8 and 16.
  - The attached detector pulses z after bits 4 and 8.
- LSB-first: MSB_FIRST=0, accept 8'h01 → x = 1,0,0,0,0,0,0,0.
- Reset mid-word: accept 8'hFF, assert rst=0 at bit 3 → next cycle x_valid=0, x=0, in_ready=1, and no further bits of 8'hFF appear.
- Backpressure: hold in_valid=1 with a new word during bits 1..7 → word not consumed until the last-bit cycle; in_data changes while in_ready=0 have no effect.
- Parity (macro defined): accept 8'h07 → x = 0,0,0,0,0,1,1,1 then parity 1; frame_last on the 9th bit. Accept 8'h03 → parity bit 0.
